// File: rtl/conv_window_gen.sv
// -----------------------------------------------------------------------------
// conv_window_gen
//   Streaming 3x3 sliding-window generator. A single-channel feature map is
//   received in raster order (row 0, col 0 first), two previous rows are kept
//   in line buffers, and every complete 3x3 window (stride 1, no padding) is
//   presented as three packed rows one cycle after its bottom-right pixel.
//
// Handshake:
//   A pixel is consumed on every rising edge where iPixValid=1 and neither
//   iRst nor iClear is high. There is no ready/backpressure path; idle cycles
//   (iPixValid=0) freeze counters, line buffers and the window register.
//   oWinValid and oMapDone are single-cycle strobes with no acknowledge.
//
// Ports:
//   iClk        clock, rising edge
//   iRst        synchronous active-high reset
//   iClear      synchronous frame abort (same effect as reset on counters,
//               window register and outputs; beats a same-cycle pixel)
//   iPixValid   pixel strobe
//   iPixData    pixel value, WI bits, passed through unmodified
//   oWindowRow1 top window row    {col c-2, col c-1, col c} of map row r-2
//   oWindowRow2 middle window row {col c-2, col c-1, col c} of map row r-1
//   oWindowRow3 bottom window row {col c-2, col c-1, col c} of map row r
//   oWinValid   one-cycle strobe per window
//   oMapDone    one-cycle pulse the cycle after the map's final window
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module conv_window_gen #(
  parameter int WI    = 8,
  parameter int IMG_W = 28,
  parameter int IMG_H = 28
) (
  input  logic            iClk,
  input  logic            iRst,
  input  logic            iClear,
  input  logic            iPixValid,
  input  logic [WI-1:0]   iPixData,
  output logic [3*WI-1:0] oWindowRow1,
  output logic [3*WI-1:0] oWindowRow2,
  output logic [3*WI-1:0] oWindowRow3,
  output logic            oWinValid,
  output logic            oMapDone
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [CW-1:0]   col_q, col_d;
  logic [RW-1:0]   row_q, row_d;

  // Line buffers: lb0 holds the previous map row, lb1 the row before that.
  // They are never reset; windows only fire from row 2 on, by which point
  // both have been rewritten for the current frame.
  logic [WI-1:0]   lb0_q [IMG_W];
  logic [WI-1:0]   lb1_q [IMG_W];

  // Window shift register, [row][col], row 0 = top, col 2 = newest column.
  logic [WI-1:0]   win_q [3][3];

  logic [3*WI-1:0] row1_q, row2_q, row3_q;
  logic [3*WI-1:0] row1_d, row2_d, row3_d;
  logic            win_valid_q;
  logic            map_pend_q;
  logic            map_done_q;

  // ---------------------------------------------------------------------------
  // Accept / position decode
  // ---------------------------------------------------------------------------
  logic          flush;
  logic          accept;
  logic          col_last;
  logic          row_last;
  logic          win_fire;
  logic          last_pix;
  logic [WI-1:0] new_col [3];

  assign flush    = iRst | iClear;
  assign accept   = iPixValid & ~flush;
  assign col_last = (col_q == COL_LAST);
  assign row_last = (row_q == ROW_LAST);
  assign win_fire = accept && (row_q >= ROW_TWO) && (col_q >= COL_TWO);
  assign last_pix = accept && col_last && row_last;

  // Incoming column, top to bottom: two rows up, one row up, current pixel.
  assign new_col[0] = lb1_q[col_q];
  assign new_col[1] = lb0_q[col_q];
  assign new_col[2] = iPixData;

  // ---------------------------------------------------------------------------
  // Counter next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (col_last) begin
        col_d = '0;
        // Wrapping past the last row starts the next map immediately.
        row_d = row_last ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  // Window rows as they will look after this pixel is shifted in; leftmost
  // pixel sits in the MSBs.
  always_comb begin
    row1_d = {win_q[0][1], win_q[0][2], new_col[0]};
    row2_d = {win_q[1][1], win_q[1][2], new_col[1]};
    row3_d = {win_q[2][1], win_q[2][2], new_col[2]};
  end

  // ---------------------------------------------------------------------------
  // Line buffers (no reset)
  // ---------------------------------------------------------------------------
  always_ff @(posedge iClk) begin
    if (accept) begin
      lb1_q[col_q] <= lb0_q[col_q];
      lb0_q[col_q] <= iPixData;
    end
  end

  // ---------------------------------------------------------------------------
  // Counters, window register and outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge iClk) begin
    if (flush) begin
      col_q       <= '0;
      row_q       <= '0;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win_q[r][c] <= '0;
        end
      end
      row1_q      <= '0;
      row2_q      <= '0;
      row3_q      <= '0;
      win_valid_q <= 1'b0;
      map_pend_q  <= 1'b0;
      map_done_q  <= 1'b0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      if (accept) begin
        for (int r = 0; r < 3; r++) begin
          win_q[r][0] <= win_q[r][1];
          win_q[r][1] <= win_q[r][2];
          win_q[r][2] <= new_col[r];
        end
      end
      // Output rows only load on a window; otherwise they hold.
      if (win_fire) begin
        row1_q <= row1_d;
        row2_q <= row2_d;
        row3_q <= row3_d;
      end
      win_valid_q <= win_fire;
      // The last pixel's window strobes next cycle; map-done follows one
      // cycle later regardless of what the input does meanwhile.
      map_pend_q  <= last_pix;
      map_done_q  <= map_pend_q;
    end
  end

  assign oWindowRow1 = row1_q;
  assign oWindowRow2 = row2_q;
  assign oWindowRow3 = row3_q;
  assign oWinValid   = win_valid_q;
  assign oMapDone    = map_done_q;

endmodule

// File: tb/tb_conv_window_gen.sv
`timescale 1ns/1ps
module tb_conv_window_gen;

  // ---------------------------------------------------------------------------
  // Clock / reset block
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int e_cnt = 0;
  always @(posedge clk) e_cnt <= e_cnt + 1;

  int tests_run    = 0;
  int tests_failed = 0;
  logic mon_en = 1'b0;

  // Small instance: 4x4 map
  logic        s_rst, s_clear, s_vld;
  logic [7:0]  s_pix;
  logic [23:0] s_r1, s_r2, s_r3;
  logic        s_wv, s_md;

  conv_window_gen #(.WI(8), .IMG_W(4), .IMG_H(4)) dut_s (
    .iClk(clk), .iRst(s_rst), .iClear(s_clear), .iPixValid(s_vld),
    .iPixData(s_pix), .oWindowRow1(s_r1), .oWindowRow2(s_r2),
    .oWindowRow3(s_r3), .oWinValid(s_wv), .oMapDone(s_md)
  );

  // Default instance: 28x28 map
  logic        d_rst, d_clear, d_vld;
  logic [7:0]  d_pix;
  logic [23:0] d_r1, d_r2, d_r3;
  logic        d_wv, d_md;

  conv_window_gen #(.WI(8), .IMG_W(28), .IMG_H(28)) dut_d (
    .iClk(clk), .iRst(d_rst), .iClear(d_clear), .iPixValid(d_vld),
    .iPixData(d_pix), .oWindowRow1(d_r1), .oWindowRow2(d_r2),
    .oWindowRow3(d_r3), .oWinValid(d_wv), .oMapDone(d_md)
  );

  // ---------------------------------------------------------------------------
  // Check helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string nm, input logic [79:0] act, input logic [79:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: actual %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm, input int act, input int exp);
    tests_run++;
    tests_failed++;
    $display("FAIL %s: actual %0d, expected %0d", nm, act, exp);
  endtask

  // ---------------------------------------------------------------------------
  // Scoreboards
  // ---------------------------------------------------------------------------
  logic [71:0] s_exp_q[$];
  int          s_due_q[$];
  int          s_done_q[$];
  logic [71:0] s_log[$];
  int          s_done_cnt = 0;
  logic [71:0] s_hold = '0;
  logic        s_zap = 1'b0;
  logic [7:0]  s_img [0:3][0:3];
  int          s_mr = 0, s_mc = 0;

  logic [71:0] d_exp_q[$];
  int          d_due_q[$];
  int          d_done_q[$];
  int          d_win_cnt = 0, d_done_cnt = 0;
  logic [7:0]  d_img [0:27][0:27];
  int          d_mr = 0, d_mc = 0;

  always @(posedge clk) s_zap <= s_rst | s_clear;

  // ---------------------------------------------------------------------------
  // Driver tasks (inputs change 1 ns after the rising edge)
  // ---------------------------------------------------------------------------
  task automatic s_cycle(input logic vld, input logic [7:0] pix,
                         input logic clr, input logic rst);
    int n;
    logic [71:0] w;
    s_vld = vld; s_pix = pix; s_clear = clr; s_rst = rst;
    @(posedge clk);
    n = e_cnt;
    if (rst || clr) begin
      s_mr = 0; s_mc = 0;
      // Anything the flushed pipeline would still have produced is cancelled.
      while (s_due_q.size() > 0 && s_due_q[s_due_q.size()-1] > n) begin
        void'(s_exp_q.pop_back()); void'(s_due_q.pop_back());
      end
      while (s_done_q.size() > 0 && s_done_q[s_done_q.size()-1] > n)
        void'(s_done_q.pop_back());
    end else if (vld) begin
      s_img[s_mr][s_mc] = pix;
      if (s_mr >= 2 && s_mc >= 2) begin
        for (int k = 0; k < 3; k++)
          w[71-24*k -: 24] = {s_img[s_mr-2+k][s_mc-2], s_img[s_mr-2+k][s_mc-1],
                              s_img[s_mr-2+k][s_mc]};
        s_exp_q.push_back(w);
        s_due_q.push_back(n + 1);
      end
      if (s_mr == 3 && s_mc == 3) s_done_q.push_back(n + 2);
      if (s_mc == 3) begin s_mc = 0; s_mr = (s_mr == 3) ? 0 : s_mr + 1; end
      else s_mc++;
    end
    #1;
    if (rst || clr)
      check(rst ? "s_rst_zero" : "s_clr_zero", {s_wv, s_md, s_r1, s_r2, s_r3}, '0);
  endtask

  task automatic s_idle(input int n);
    repeat (n) s_cycle(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic s_map(input logic [7:0] base, input logic [7:0] step, input int gap_max);
    for (int i = 0; i < 16; i++) begin
      if (i > 0 && gap_max > 0)
        repeat ($urandom_range(0, gap_max)) s_cycle(1'b0, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
      s_cycle(1'b1, base + step * 8'(i), 1'b0, 1'b0);
    end
  endtask

  task automatic d_cycle(input logic vld, input logic [7:0] pix);
    int n;
    logic [71:0] w;
    d_vld = vld; d_pix = pix;
    @(posedge clk);
    n = e_cnt;
    if (vld) begin
      d_img[d_mr][d_mc] = pix;
      if (d_mr >= 2 && d_mc >= 2) begin
        for (int k = 0; k < 3; k++)
          w[71-24*k -: 24] = {d_img[d_mr-2+k][d_mc-2], d_img[d_mr-2+k][d_mc-1],
                              d_img[d_mr-2+k][d_mc]};
        d_exp_q.push_back(w);
        d_due_q.push_back(n + 1);
      end
      if (d_mr == 27 && d_mc == 27) d_done_q.push_back(n + 2);
      if (d_mc == 27) begin d_mc = 0; d_mr = (d_mr == 27) ? 0 : d_mr + 1; end
      else d_mc++;
    end
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Monitors (sample on the falling edge)
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (mon_en) begin
      if (s_zap) s_hold = '0;
      if (s_wv) begin
        if (s_exp_q.size() == 0) fail_now("s_win_extra", e_cnt, 0);
        else begin
          check("s_win_data", {s_r1, s_r2, s_r3}, s_exp_q.pop_front());
          check("s_win_lat", e_cnt, s_due_q.pop_front());
        end
        s_log.push_back({s_r1, s_r2, s_r3});
        s_hold = {s_r1, s_r2, s_r3};
      end else begin
        check("s_hold", {s_r1, s_r2, s_r3}, s_hold);
        if (s_due_q.size() > 0 && s_due_q[0] <= e_cnt) begin
          fail_now("s_win_missing", e_cnt, s_due_q[0]);
          void'(s_exp_q.pop_front()); void'(s_due_q.pop_front());
        end
      end
      if (s_md) begin
        s_done_cnt++;
        if (s_done_q.size() == 0) fail_now("s_done_extra", e_cnt, 0);
        else check("s_done_lat", e_cnt, s_done_q.pop_front());
      end else if (s_done_q.size() > 0 && s_done_q[0] <= e_cnt) begin
        fail_now("s_done_missing", e_cnt, s_done_q[0]);
        void'(s_done_q.pop_front());
      end

      if (d_wv) begin
        d_win_cnt++;
        if (d_exp_q.size() == 0) fail_now("d_win_extra", e_cnt, 0);
        else begin
          check("d_win_data", {d_r1, d_r2, d_r3}, d_exp_q.pop_front());
          check("d_win_lat", e_cnt, d_due_q.pop_front());
        end
      end else if (d_due_q.size() > 0 && d_due_q[0] <= e_cnt) begin
        fail_now("d_win_missing", e_cnt, d_due_q[0]);
        void'(d_exp_q.pop_front()); void'(d_due_q.pop_front());
      end
      if (d_md) begin
        d_done_cnt++;
        if (d_done_q.size() == 0) fail_now("d_done_extra", e_cnt, 0);
        else check("d_done_lat", e_cnt, d_done_q.pop_front());
      end else if (d_done_q.size() > 0 && d_done_q[0] <= e_cnt) begin
        fail_now("d_done_missing", e_cnt, d_done_q[0]);
        void'(d_done_q.pop_front());
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Directed vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [7:0]  base;
    logic [7:0]  step;
    int          gap_max;
    logic [71:0] first_w;
    logic [71:0] last_w;
  } vec_t;

  vec_t vecs [4];

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    int b;
    int dc;
    s_rst = 1'b1; s_clear = 1'b0; s_vld = 1'b0; s_pix = '0;
    d_rst = 1'b1; d_clear = 1'b0; d_vld = 1'b0; d_pix = '0;

    // 0..15 continuous, then 100..115 back-to-back, then 0..15 with gaps,
    // then all -1 with gaps.
    vecs[0] = '{8'h00, 8'h01, 0, {24'h000102, 24'h040506, 24'h08090A},
                                 {24'h050607, 24'h090A0B, 24'h0D0E0F}};
    vecs[1] = '{8'h64, 8'h01, 0, {24'h646566, 24'h68696A, 24'h6C6D6E},
                                 {24'h696A6B, 24'h6D6E6F, 24'h717273}};
    vecs[2] = '{8'h00, 8'h01, 3, {24'h000102, 24'h040506, 24'h08090A},
                                 {24'h050607, 24'h090A0B, 24'h0D0E0F}};
    vecs[3] = '{8'hFF, 8'h00, 2, {24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF},
                                 {24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF}};

    repeat (3) s_cycle(1'b0, 8'h00, 1'b0, 1'b1);
    d_rst = 1'b0;
    s_rst = 1'b0;
    mon_en = 1'b1;

    // Table-driven maps on the 4x4 instance
    for (int v = 0; v < 4; v++) s_map(vecs[v].base, vecs[v].step, vecs[v].gap_max);
    s_idle(4);
    check("s_tbl_count", s_log.size(), 16);
    check("s_tbl_done", s_done_cnt, 4);
    if (s_log.size() >= 16) begin
      for (int v = 0; v < 4; v++) begin
        check($sformatf("s_tbl%0d_first", v), s_log[4*v], vecs[v].first_w);
        check($sformatf("s_tbl%0d_last", v), s_log[4*v+3], vecs[v].last_w);
      end
    end

    // Reset mid-map after pixel 9; a pixel strobed during reset is dropped
    for (int i = 0; i < 10; i++) s_cycle(1'b1, 8'(i), 1'b0, 1'b0);
    s_cycle(1'b0, 8'h00, 1'b0, 1'b1);
    s_cycle(1'b1, 8'h77, 1'b0, 1'b1);
    b = s_log.size();
    s_map(8'h00, 8'h01, 0);
    s_idle(3);
    check("s_rst_count", s_log.size() - b, 4);
    if (s_log.size() >= b + 4) begin
      check("s_rst_first", s_log[b], vecs[0].first_w);
      check("s_rst_last", s_log[b+3], vecs[0].last_w);
    end

    // Clear mid-map with a same-cycle pixel
    for (int i = 0; i < 10; i++) s_cycle(1'b1, 8'(i), 1'b0, 1'b0);
    s_cycle(1'b1, 8'h55, 1'b1, 1'b0);
    b = s_log.size();
    s_map(8'h00, 8'h01, 0);
    s_idle(3);
    check("s_clr_count", s_log.size() - b, 4);
    if (s_log.size() >= b + 4) begin
      check("s_clr_first", s_log[b], vecs[0].first_w);
      check("s_clr_last", s_log[b+3], vecs[0].last_w);
    end

    // Clear the cycle after the last pixel: final window still strobes,
    // pending map-done is cancelled
    dc = s_done_cnt;
    b = s_log.size();
    s_map(8'h00, 8'h01, 0);
    s_cycle(1'b0, 8'h00, 1'b1, 1'b0);
    s_idle(4);
    check("s_clr_done_drop", s_done_cnt, dc);
    check("s_clr_last_win_count", s_log.size() - b, 4);

    // Default geometry: four 28x28 passes of random signed pixels
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 784; i++) begin
        if ($urandom_range(0, 3) == 0) d_cycle(1'b0, 8'($urandom_range(0, 255)));
        d_cycle(1'b1, 8'($urandom_range(0, 255)));
      end
    end
    repeat (4) d_cycle(1'b0, 8'h00);
    check("d_win_count", d_win_cnt, 4 * 676);
    check("d_done_count", d_done_cnt, 4);

    check("s_q_empty", s_exp_q.size() + s_done_q.size(), 0);
    check("d_q_empty", d_exp_q.size() + d_done_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
